delta_accum_scheduler: RTL and testbench

- Sequences the per-channel index lists that drive the output accumulation buffer.
- Generates `w_en`, `index_count` and `enable` each cycle. Walks every input channel's list from entry 0 to `index_len-1`.
- Arbitrates so at most one input channel updates a given output channel per cycle. Grant priority rotates round-robin.
- Sits between the index-list producer (delta encoder) and the output accumulation buffer.

---
 rtl/delta_accum_scheduler_pkg.sv | 38 +++
 rtl/delta_accum_scheduler_if.sv | 29 ++
 rtl/delta_accum_scheduler_arb.sv | 43 ++++
 rtl/delta_accum_scheduler.sv | 118 +++++++++++
 tb/tb_delta_accum_scheduler.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/delta_accum_scheduler_pkg.sv
// Shared types, geometry constants and field helper for the delta accumulation scheduler.
// Conflict arbitration is compiled in with DELTA_SCHED_CONFLICT_ARB_EN.
package delta_sched_pkg;

    localparam int INPUT_CHANNEL      = 4;
    localparam int INDEX_NUM          = 4;
    localparam int INDEX_NUM_LOG      = 2;
    localparam int INDEX_WIDTH        = 8;
    localparam int OUTPUT_CHANNEL_LOG = 3;
    localparam int KERNEL_HEIGHT_LOG  = 1;
    localparam int KERNEL_WIDTH_LOG   = 1;

    localparam int IN_CH       = INPUT_CHANNEL;
    localparam int IDX_NUM     = INDEX_NUM;
    localparam int IDX_NUM_LOG = INDEX_NUM_LOG;
    localparam int IDX_W       = INDEX_WIDTH;
    localparam int OC_LOG      = OUTPUT_CHANNEL_LOG;
    localparam int KOFF        = KERNEL_HEIGHT_LOG + KERNEL_WIDTH_LOG;
    localparam int RR_W        = (IN_CH > 1) ? $clog2(IN_CH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    typedef logic [IDX_NUM_LOG-1:0] idx_ptr_t;
    typedef logic [IDX_NUM_LOG:0]   idx_len_t;
    typedef logic [OC_LOG-1:0]      oc_t;

    localparam idx_len_t LEN_MAX = idx_len_t'(IDX_NUM);

    // Output-channel field of one index entry; bits below KOFF are kernel position.
    function automatic oc_t oc_of(input logic [IDX_W-1:0] entry);
        return oc_t'(entry >> KOFF);
    endfunction

endpackage

// File: rtl/delta_accum_scheduler_if.sv
// Bus between the index-list producer (master) and the scheduler (slave).
// Optional conflict arbitration inside the scheduler: DELTA_SCHED_CONFLICT_ARB_EN.
interface delta_accum_scheduler_if;
    import delta_sched_pkg::*;

    // start is a one-cycle request honoured only while idle; lists and lengths
    // must stay stable until done; w_en[c] means entry index_count[c] is consumed now.
    logic                                      start;
    logic                                      hold;
    idx_len_t [IN_CH-1:0]                      index_len;
    logic [IN_CH-1:0][IDX_NUM-1:0][IDX_W-1:0]  index_vals;
    logic [IN_CH-1:0]                          w_en;
    idx_ptr_t [IN_CH-1:0]                      index_count;
    logic                                      enable;
    logic                                      busy;
    logic                                      done;
    sched_state_t                              state;

    modport master (
        output start, hold, index_len, index_vals,
        input  w_en, index_count, enable, busy, done, state
    );

    modport slave (
        input  start, hold, index_len, index_vals,
        output w_en, index_count, enable, busy, done, state
    );

endinterface

// File: rtl/delta_accum_scheduler_arb.sv
// Round-robin grant of candidate channels, one grant per output channel per cycle.
// Without DELTA_SCHED_CONFLICT_ARB_EN every candidate is granted unconditionally.
module rr_conflict_arbiter
    import delta_sched_pkg::*;
(
    input  logic [IN_CH-1:0] cand_i,
`ifdef DELTA_SCHED_CONFLICT_ARB_EN
    input  oc_t [IN_CH-1:0]  tgt_i,
    input  logic [RR_W-1:0]  rr_i,
`endif
    output logic [IN_CH-1:0] grant_o
);

`ifdef DELTA_SCHED_CONFLICT_ARB_EN
    localparam int SUM_W = RR_W + 1;

    logic [(1<<OC_LOG)-1:0] taken;
    logic [SUM_W-1:0]       sum;
    logic [RR_W-1:0]        ch;

    // taken marks output channels already claimed earlier in this scan.
    always_comb begin
        grant_o = '0;
        taken   = '0;
        sum     = '0;
        ch      = '0;
        for (int i = 0; i < IN_CH; i++) begin
            sum = {1'b0, rr_i} + SUM_W'(i);
            if (sum >= SUM_W'(IN_CH)) begin
                sum = sum - SUM_W'(IN_CH);
            end
            ch = sum[RR_W-1:0];
            if (cand_i[ch] && !taken[tgt_i[ch]]) begin
                grant_o[ch]        = 1'b1;
                taken[tgt_i[ch]]   = 1'b1;
            end
        end
    end
`else
    assign grant_o = cand_i;
`endif

endmodule

// File: rtl/delta_accum_scheduler.sv
// Walks each input channel's index list and issues per-channel write grants.
// DELTA_SCHED_CONFLICT_ARB_EN enables output-channel conflict arbitration.
module delta_accum_scheduler
    import delta_sched_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    delta_accum_scheduler_if.slave  bus
);

    sched_state_t          state_q, state_d;
    idx_len_t [IN_CH-1:0]  rem_q, rem_d;
    idx_ptr_t [IN_CH-1:0]  cnt_q, cnt_d;
    logic [IN_CH-1:0]      cand;
    logic [IN_CH-1:0]      grant;
    logic [IN_CH-1:0]      w_en;
    logic                  run_go;
    logic                  any_len;

`ifdef DELTA_SCHED_CONFLICT_ARB_EN
    logic [RR_W-1:0]       rr_q, rr_d;
    oc_t [IN_CH-1:0]       tgt;

    always_comb begin
        for (int c = 0; c < IN_CH; c++) begin
            tgt[c] = oc_of(bus.index_vals[c][cnt_q[c]]);
        end
    end
`endif

    always_comb begin
        for (int c = 0; c < IN_CH; c++) begin
            cand[c] = (rem_q[c] != '0);
        end
    end

    rr_conflict_arbiter u_arb (
        .cand_i  (cand),
`ifdef DELTA_SCHED_CONFLICT_ARB_EN
        .tgt_i   (tgt),
        .rr_i    (rr_q),
`endif
        .grant_o (grant)
    );

    assign run_go = (state_q == RUN) && !bus.hold;
    assign w_en   = run_go ? grant : '0;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        any_len = 1'b0;
`ifdef DELTA_SCHED_CONFLICT_ARB_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    for (int c = 0; c < IN_CH; c++) begin
                        rem_d[c] = (bus.index_len[c] > LEN_MAX) ? LEN_MAX : bus.index_len[c];
                        cnt_d[c] = '0;
                        any_len  = any_len | (bus.index_len[c] != '0);
                    end
`ifdef DELTA_SCHED_CONFLICT_ARB_EN
                    rr_d = '0;
`endif
                    state_d = any_len ? RUN : DONE;
                end
            end
            RUN: begin
                if (!bus.hold) begin
                    for (int c = 0; c < IN_CH; c++) begin
                        if (w_en[c]) begin
                            cnt_d[c] = cnt_q[c] + idx_ptr_t'(1);
                            rem_d[c] = rem_q[c] - idx_len_t'(1);
                        end
                    end
`ifdef DELTA_SCHED_CONFLICT_ARB_EN
                    rr_d = (rr_q == RR_W'(IN_CH - 1)) ? '0 : rr_q + RR_W'(1);
`endif
                end
                // Exit only once a cycle has observed every list drained.
                if (rem_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
`ifdef DELTA_SCHED_CONFLICT_ARB_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
`ifdef DELTA_SCHED_CONFLICT_ARB_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign bus.w_en        = w_en;
    assign bus.index_count = cnt_q;
    assign bus.enable      = run_go;
    assign bus.busy        = (state_q == RUN) || (state_q == DONE);
    assign bus.done        = (state_q == DONE);
    assign bus.state       = state_q;

endmodule

// File: tb/tb_delta_accum_scheduler.sv
// Directed bench for delta_accum_scheduler; expectations follow DELTA_SCHED_CONFLICT_ARB_EN.
module tb_delta_accum_scheduler;
    import delta_sched_pkg::*;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    delta_accum_scheduler_if bus();

    delta_accum_scheduler dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] ent(input logic [2:0] oc, input logic [2:0] hi, input logic [1:0] lo);
        ent = {hi, oc, lo};
    endfunction

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.hold = 1'b0;
        bus.index_len = '0;
        bus.index_vals = '0;
        tick();
        tick();
        n_checks++; if (bus.state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", bus.state, IDLE); end
        n_checks++; if (bus.w_en !== 4'b0000) begin n_fail++; $display("FAIL reset_w_en got %b exp 0000", bus.w_en); end
        n_checks++; if (bus.index_count !== 8'h00) begin n_fail++; $display("FAIL reset_index_count got %h exp 00", bus.index_count); end
        n_checks++; if ({bus.enable, bus.busy, bus.done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {bus.enable, bus.busy, bus.done}); end
        reset = 1'b0;
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_distinct();
        idx_ptr_t p;
        for (int c = 0; c < IN_CH; c++) begin
            bus.index_len[c] = 3'd3;
            for (int k = 0; k < IDX_NUM; k++) bus.index_vals[c][k] = ent(3'(c), 3'(k + 1), 2'(c + k));
        end
        do_start();
        for (int i = 0; i < 3; i++) begin
            p = idx_ptr_t'(i);
            n_checks++; if (bus.w_en !== 4'b1111) begin n_fail++; $display("FAIL dist_w_en cyc%0d got %b exp 1111", i, bus.w_en); end
            n_checks++; if (bus.index_count !== {p, p, p, p}) begin n_fail++; $display("FAIL dist_index_count cyc%0d got %h exp %h", i, bus.index_count, {p, p, p, p}); end
            n_checks++; if (bus.enable !== 1'b1) begin n_fail++; $display("FAIL dist_enable cyc%0d got %b exp 1", i, bus.enable); end
            if (i == 1) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        n_checks++; if (bus.w_en !== 4'b0000 || bus.state !== RUN) begin n_fail++; $display("FAIL dist_drain got w_en=%b state=%0d exp 0000/RUN", bus.w_en, bus.state); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL dist_done_early got %b exp 0", bus.done); end
        tick();
        n_checks++; if ({bus.done, bus.busy, bus.enable} !== 3'b110) begin n_fail++; $display("FAIL dist_done got done/busy/en=%b exp 110", {bus.done, bus.busy, bus.enable}); end
        tick();
        n_checks++; if ({bus.done, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL dist_idle got done/busy=%b exp 00", {bus.done, bus.busy}); end
    endtask

    task automatic test_conflict();
        logic [3:0] exp_w;
        int         n_grant;
        for (int c = 0; c < IN_CH; c++) begin
            bus.index_len[c] = 3'd2;
            for (int k = 0; k < IDX_NUM; k++) bus.index_vals[c][k] = ent(3'd5, 3'(c), 2'(k));
        end
`ifdef DELTA_SCHED_CONFLICT_ARB_EN
        n_grant = 8;
`else
        n_grant = 2;
`endif
        do_start();
        for (int i = 0; i < n_grant; i++) begin
`ifdef DELTA_SCHED_CONFLICT_ARB_EN
            exp_w = 4'b0001 << (i % 4);
`else
            exp_w = 4'b1111;
`endif
            n_checks++; if (bus.w_en !== exp_w) begin n_fail++; $display("FAIL conflict_w_en cyc%0d got %b exp %b", i, bus.w_en, exp_w); end
            tick();
        end
        n_checks++; if (bus.w_en !== 4'b0000 || bus.state !== RUN) begin n_fail++; $display("FAIL conflict_drain got w_en=%b state=%0d exp 0000/RUN", bus.w_en, bus.state); end
        tick();
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL conflict_done got %b exp 1", bus.done); end
        tick();
    endtask

    task automatic test_zero_len();
        bus.index_len = '0;
        do_start();
        n_checks++; if (bus.state !== DONE || bus.done !== 1'b1) begin n_fail++; $display("FAIL zero_done got state=%0d done=%b exp DONE/1", bus.state, bus.done); end
        n_checks++; if (bus.w_en !== 4'b0000 || bus.enable !== 1'b0) begin n_fail++; $display("FAIL zero_quiet got w_en=%b en=%b exp 0000/0", bus.w_en, bus.enable); end
        tick();
        n_checks++; if (bus.state !== IDLE || bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle got state=%0d done=%b busy=%b", bus.state, bus.done, bus.busy); end
    endtask

    task automatic test_hold();
        logic [3:0] exp_w [2];
        logic [7:0] exp_ic [2];
        bus.index_len = '0;
        bus.index_len[0] = 3'd2;
        bus.index_len[2] = 3'd1;
        for (int c = 0; c < IN_CH; c++)
            for (int k = 0; k < IDX_NUM; k++) bus.index_vals[c][k] = ent(3'd1, 3'd7, 2'd3);
        bus.index_vals[0][1] = ent(3'd2, 3'd0, 2'd0);
`ifdef DELTA_SCHED_CONFLICT_ARB_EN
        exp_w[0] = 4'b0001; exp_ic[0] = 8'h00;
        exp_w[1] = 4'b0101; exp_ic[1] = 8'h01;
`else
        exp_w[0] = 4'b0101; exp_ic[0] = 8'h00;
        exp_w[1] = 4'b0001; exp_ic[1] = 8'h11;
`endif
        bus.hold = 1'b1;
        do_start();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.w_en !== 4'b0000 || bus.enable !== 1'b0) begin n_fail++; $display("FAIL hold_quiet cyc%0d got w_en=%b en=%b", i, bus.w_en, bus.enable); end
            n_checks++; if (bus.index_count !== 8'h00 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL hold_frozen cyc%0d got ic=%h busy=%b", i, bus.index_count, bus.busy); end
            tick();
        end
        bus.hold = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (bus.w_en !== exp_w[i]) begin n_fail++; $display("FAIL hold_w_en step%0d got %b exp %b", i, bus.w_en, exp_w[i]); end
            n_checks++; if (bus.index_count !== exp_ic[i]) begin n_fail++; $display("FAIL hold_ic step%0d got %h exp %h", i, bus.index_count, exp_ic[i]); end
            tick();
        end
        n_checks++; if (bus.w_en !== 4'b0000 || bus.state !== RUN) begin n_fail++; $display("FAIL hold_drain got w_en=%b state=%0d", bus.w_en, bus.state); end
        tick();
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL hold_done got %b exp 1", bus.done); end
        tick();
    endtask

    task automatic test_len_clamp();
        bus.index_len = '0;
        bus.index_len[0] = 3'd7;
        for (int k = 0; k < IDX_NUM; k++) bus.index_vals[0][k] = ent(3'(k), 3'd3, 2'd2);
        do_start();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.w_en !== 4'b0001) begin n_fail++; $display("FAIL clamp_w_en cyc%0d got %b exp 0001", i, bus.w_en); end
            n_checks++; if (bus.index_count[0] !== idx_ptr_t'(i)) begin n_fail++; $display("FAIL clamp_ic cyc%0d got %0d exp %0d", i, bus.index_count[0], i); end
            tick();
        end
        n_checks++; if (bus.w_en !== 4'b0000 || bus.state !== RUN) begin n_fail++; $display("FAIL clamp_drain got w_en=%b state=%0d", bus.w_en, bus.state); end
        tick();
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL clamp_done got %b exp 1", bus.done); end
        tick();
    endtask

    task automatic test_mid_reset();
        for (int c = 0; c < IN_CH; c++) begin
            bus.index_len[c] = 3'd3;
            for (int k = 0; k < IDX_NUM; k++) bus.index_vals[c][k] = ent(3'(c), 3'd1, 2'(k));
        end
        do_start();
        tick();
        tick();
        n_checks++; if (bus.index_count[0] !== 2'd2) begin n_fail++; $display("FAIL midrst_pre got %0d exp 2", bus.index_count[0]); end
        reset = 1'b1;
        tick();
        n_checks++; if (bus.state !== IDLE || bus.w_en !== 4'b0000 || bus.index_count !== 8'h00) begin n_fail++; $display("FAIL midrst_clear got state=%0d w_en=%b ic=%h", bus.state, bus.w_en, bus.index_count); end
        n_checks++; if ({bus.enable, bus.busy, bus.done} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags got %b exp 000", {bus.enable, bus.busy, bus.done}); end
        reset = 1'b0;
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got busy=%b exp 0", bus.busy); end
        do_start();
        n_checks++; if (bus.index_count !== 8'h00 || bus.w_en !== 4'b1111) begin n_fail++; $display("FAIL midrst_restart got ic=%h w_en=%b exp 00/1111", bus.index_count, bus.w_en); end
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (bus.state !== IDLE) begin n_fail++; $display("FAIL midrst_finish got state=%0d exp IDLE", bus.state); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_distinct();
        test_conflict();
        test_zero_len();
        test_hold();
        test_len_clamp();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
